hwpe_stream_tcdm_load_seq: RTL and testbench

Load sequencer sitting directly upstream of the TCDM load FIFO stage. On a start pulse it generates a strided sequence of 32-bit TCDM read requests, bounds the number of in-flight reads with a credit counter, and forwards the returned words as an HWPE stream. It also drives the response-pop ready back into the FIFO stage. It is the producer of `tcdm_slave` requests and the consumer of its `r_data`/`r_valid` for a streamer source.

---
 rtl/hwpe_stream_tcdm_load_seq_if.sv | 28 ++
 rtl/hwpe_stream_tcdm_load_seq.sv | 138 +++++++++++++
 tb/tb_hwpe_stream_tcdm_load_seq.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_tcdm_load_seq_if.sv
// TCDM request/response and HWPE stream interfaces used by the load sequencer.
// A stream word transfers on a cycle where valid and ready are both high; data must stay put while valid waits for ready.

interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_load_seq.sv
// Strided TCDM load sequencer: issues credit-limited read requests and forwards returned words as a stream.
// Handshakes: a request transfers when req & gnt; a response transfers when r_valid & stream.ready.

module hwpe_stream_tcdm_load_seq #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [31:0]          base_addr_i,
    input  logic [31:0]          stride_i,
    input  logic [CNT_WIDTH-1:0] len_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 resp_ready_o,
    output logic [1:0]           state_o,
    hwpe_stream_intf_tcdm.master   tcdm,
    hwpe_stream_intf_stream.source stream
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          stride_q, stride_d;
    logic [CNT_WIDTH-1:0] len_q, len_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [OW-1:0]        outst_q, outst_d;
    logic                 done_q, done_d;
    logic                 req, grant, consume;

    // Credit check uses only registered state so req never depends on gnt/r_valid.
    assign req     = (state_q == RUN) && (outst_q < MAX_OUT);
    assign grant   = req && tcdm.gnt;
    // Stray responses (e.g. after a clear) pass through but never underflow the counter.
    assign consume = tcdm.r_valid && stream.ready && (outst_q != '0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        len_d    = len_q;
        issued_d = issued_q;
        outst_d  = outst_q;
        done_d   = 1'b0;

        if (grant && !consume) begin
            outst_d = outst_q + OW'(1);
        end else if (!grant && consume) begin
            outst_d = outst_q - OW'(1);
        end
        if (grant) begin
            addr_d   = addr_q + stride_q;
            issued_d = issued_q + CNT_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d   = base_addr_i;
                    stride_d = stride_i;
                    len_d    = len_i;
                    issued_d = '0;
                    outst_d  = '0;
                    state_d  = (len_i != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (grant && (issued_q == len_q - CNT_WIDTH'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Looking at the next count lets done follow the last pop by one cycle.
                if (outst_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (clear_i) begin
            state_d  = IDLE;
            addr_d   = '0;
            stride_d = '0;
            len_d    = '0;
            issued_d = '0;
            outst_d  = '0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            issued_q <= '0;
            outst_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            len_q    <= len_d;
            issued_q <= issued_d;
            outst_q  <= outst_d;
            done_q   <= done_d;
        end
    end

    assign tcdm.req  = req;
    assign tcdm.add  = addr_q;
    assign tcdm.wen  = 1'b1;
    assign tcdm.be   = 4'hF;
    assign tcdm.data = '0;

    assign stream.data  = tcdm.r_data;
    assign stream.valid = tcdm.r_valid;
    assign stream.strb  = '1;
    assign resp_ready_o = stream.ready;

    assign busy_o  = (state_q != IDLE);
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_seq.sv
// Directed bench for the TCDM load sequencer with a response-FIFO model and an expected-word scoreboard.

module tb_hwpe_stream_tcdm_load_seq;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic [15:0] len;
    logic        busy_o, done_o, resp_ready_o;
    logic [1:0]  state_o;

    hwpe_stream_intf_tcdm tcdm ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) stream ();

    hwpe_stream_tcdm_load_seq #(
        .MAX_OUTSTANDING(MAXO),
        .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .clear_i(clear),
        .start_i(start),
        .base_addr_i(base_addr),
        .stride_i(stride),
        .len_i(len),
        .busy_o(busy_o),
        .done_o(done_o),
        .resp_ready_o(resp_ready_o),
        .state_o(state_o),
        .tcdm(tcdm),
        .stream(stream)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int m_checks = 0;
    int m_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mchk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        m_checks++;
        assert (obs === exp) else begin
            m_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- response FIFO model (load FIFO stage) ----------------
    logic [31:0] rq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq.delete();
            tcdm.r_valid <= 1'b0;
            tcdm.r_data  <= '0;
        end else begin
            if (tcdm.r_valid && resp_ready_o) void'(rq.pop_front());
            if (tcdm.req && tcdm.gnt) rq.push_back(mem_word(tcdm.add));
            tcdm.r_valid <= (rq.size() != 0);
            tcdm.r_data  <= (rq.size() != 0) ? rq[0] : 32'h0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr   = '0;
    logic [31:0] exp_stride = '0;
    int          model_out  = 0;
    int          peak_out   = 0;
    int          rx_cnt     = 0;
    int          n_done     = 0;
    logic        hold_pend  = 1'b0;
    logic [31:0] hold_add   = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            mchk("resp_ready_passthru", {31'b0, resp_ready_o}, {31'b0, stream.ready});
            mchk("credit_limit", {31'b0, tcdm.req && (model_out >= MAXO)}, 32'h0);
            if (hold_pend) begin
                mchk("hold_req", {31'b0, tcdm.req}, 32'h1);
                mchk("hold_add", tcdm.add, hold_add);
            end
            hold_pend = tcdm.req && !tcdm.gnt && !clear;
            hold_add  = tcdm.add;
            if (tcdm.req) begin
                mchk("req_wen", {31'b0, tcdm.wen}, 32'h1);
                mchk("req_be", {28'b0, tcdm.be}, 32'hF);
            end
            if (tcdm.req && tcdm.gnt) begin
                mchk("grant_add", tcdm.add, exp_addr);
                exp_q.push_back(mem_word(exp_addr));
                exp_addr = exp_addr + exp_stride;
                model_out++;
            end
            if (stream.valid && resp_ready_o) begin
                rx_cnt++;
                mchk("strb", {28'b0, stream.strb}, 32'hF);
                if (exp_q.size() == 0) mchk("unexpected_word", 32'h1, 32'h0);
                else mchk("stream_data", stream.data, exp_q.pop_front());
                if (model_out > 0) model_out--;
            end
            if (clear) model_out = 0;
            if (model_out > peak_out) peak_out = model_out;
            if (done_o) n_done++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
        exp_addr   = b;
        exp_stride = s;
        base_addr  = b;
        stride     = s;
        len        = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (!done_o && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'b0, done_o}, 32'h1);
        chk({tag, "_busy"}, {31'b0, busy_o}, 32'h0);
        tick();
        chk({tag, "_pulse"}, {31'b0, done_o}, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int rx0, d0;
        logic [31:0] wrap_tab [4];
        wrap_tab[0] = 32'h0000_0008;
        wrap_tab[1] = 32'h0000_0004;
        wrap_tab[2] = 32'h0000_0000;
        wrap_tab[3] = 32'hFFFF_FFFC;

        rst_n = 1'b0; clear = 1'b0; start = 1'b0;
        base_addr = '0; stride = '0; len = '0;
        tcdm.gnt = 1'b0; stream.ready = 1'b0;
        tick(); tick();
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_req", {31'b0, tcdm.req}, 32'h0);
        chk("rst_add", tcdm.add, 32'h0);
        chk("rst_state", {30'b0, state_o}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Back-to-back issue, one request per cycle
        tcdm.gnt = 1'b1; stream.ready = 1'b1;
        rx0 = rx_cnt; d0 = n_done;
        do_start(32'h1000, 32'h4, 16'd8);
        for (int i = 0; i < 8; i++) begin
            chk("t1_req", {31'b0, tcdm.req}, 32'h1);
            chk("t1_add", tcdm.add, 32'h1000 + 32'(4 * i));
            tick();
        end
        chk("t1_drain_req", {31'b0, tcdm.req}, 32'h0);
        chk("t1_drain_state", {30'b0, state_o}, 32'h2);
        chk("t1_drain_done", {31'b0, done_o}, 32'h0);
        tick();
        chk("t1_done", {31'b0, done_o}, 32'h1);
        chk("t1_idle_busy", {31'b0, busy_o}, 32'h0);
        chk("t1_idle_state", {30'b0, state_o}, 32'h0);
        tick();
        chk("t1_done_once", {31'b0, done_o}, 32'h0);
        chk("t1_words", 32'(rx_cnt - rx0), 32'd8);
        chk("t1_done_cnt", 32'(n_done - d0), 32'd1);

        // Address wrap
        rx0 = rx_cnt;
        do_start(32'h8, 32'hFFFF_FFFC, 16'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_add", tcdm.add, wrap_tab[i]);
            tick();
        end
        wait_done("t2_done", 20);
        chk("t2_words", 32'(rx_cnt - rx0), 32'd4);

        // Credit limit with a stalled consumer
        rx0 = rx_cnt; peak_out = 0;
        stream.ready = 1'b0;
        do_start(32'h2000, 32'h4, 16'd10);
        for (int i = 0; i < 4; i++) begin
            chk("t3_req_early", {31'b0, tcdm.req}, 32'h1);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            chk("t3_req_stalled", {31'b0, tcdm.req}, 32'h0);
            chk("t3_outstanding", 32'(model_out), 32'd4);
            tick();
        end
        chk("t3_valid", {31'b0, stream.valid}, 32'h1);
        chk("t3_head_data", stream.data, mem_word(32'h2000));
        chk("t3_resp_ready_low", {31'b0, resp_ready_o}, 32'h0);
        stream.ready = 1'b1;
        wait_done("t3_done", 200);
        chk("t3_words", 32'(rx_cnt - rx0), 32'd10);
        chk("t3_peak", 32'(peak_out), 32'd4);

        // Random grant and ready
        rx0 = rx_cnt; d0 = n_done; peak_out = 0;
        do_start(32'h4000, 32'h24, 16'd64);
        for (int k = 0; k < 3000 && !done_o; k++) begin
            tcdm.gnt     = 1'($urandom_range(0, 1));
            stream.ready = 1'($urandom_range(0, 1));
            tick();
        end
        chk("t4_done", {31'b0, done_o}, 32'h1);
        tcdm.gnt = 1'b1; stream.ready = 1'b1;
        tick();
        chk("t4_words", 32'(rx_cnt - rx0), 32'd64);
        chk("t4_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t4_exp_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_out_zero", 32'(model_out), 32'd0);
        chk("t4_peak_ok", {31'b0, peak_out <= MAXO}, 32'h1);

        // Zero length
        rx0 = rx_cnt;
        do_start(32'h3000, 32'h4, 16'd0);
        chk("t5_len0_state", {30'b0, state_o}, 32'h2);
        chk("t5_len0_busy", {31'b0, busy_o}, 32'h1);
        chk("t5_len0_req", {31'b0, tcdm.req}, 32'h0);
        tick();
        chk("t5_len0_done", {31'b0, done_o}, 32'h1);
        chk("t5_len0_idle", {30'b0, state_o}, 32'h0);
        tick();
        chk("t5_len0_words", 32'(rx_cnt - rx0), 32'd0);

        // Start while busy is ignored
        rx0 = rx_cnt; d0 = n_done;
        stream.ready = 1'b0;
        do_start(32'h5000, 32'h4, 16'd4);
        tick();
        base_addr = 32'h9000; stride = 32'h100; len = 16'd7; start = 1'b1;
        tick();
        start = 1'b0;
        stream.ready = 1'b1;
        wait_done("t5_busy_done", 100);
        tick(); tick();
        chk("t5_busy_words", 32'(rx_cnt - rx0), 32'd4);
        chk("t5_busy_done_cnt", 32'(n_done - d0), 32'd1);
        chk("t5_busy_idle", {31'b0, busy_o}, 32'h0);

        // Clear mid-run
        rx0 = rx_cnt; d0 = n_done;
        stream.ready = 1'b0;
        do_start(32'h6000, 32'h4, 16'd8);
        tick(); tick(); tick();
        tcdm.gnt = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_state", {30'b0, state_o}, 32'h0);
        chk("t6_req", {31'b0, tcdm.req}, 32'h0);
        chk("t6_busy", {31'b0, busy_o}, 32'h0);
        chk("t6_add", tcdm.add, 32'h0);
        chk("t6_done", {31'b0, done_o}, 32'h0);
        stream.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6_no_done", {31'b0, done_o}, 32'h0);
        end
        chk("t6_stale_words", 32'(rx_cnt - rx0), 32'd3);
        chk("t6_stale_empty", 32'(exp_q.size()), 32'd0);
        chk("t6_done_cnt", 32'(n_done - d0), 32'd0);
        rx0 = rx_cnt;
        tcdm.gnt = 1'b1;
        do_start(32'h7000, 32'h8, 16'd3);
        chk("t6_restart_add", tcdm.add, 32'h7000);
        wait_done("t6_restart_done", 50);
        chk("t6_restart_words", 32'(rx_cnt - rx0), 32'd3);

        tick(); tick();
        n_checks = n_checks + m_checks;
        n_fail   = n_fail + m_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
